// File: rtl/dmem_store_buffer.sv
// Data-memory store buffer: posted stores drain in the background,
// loads take bus priority, read-after-write hits drain first.
module dmem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          write,
    input  logic [AW-1:0] write_address,
    input  logic [31:0]   DATA_out,
    input  logic [1:0]    size,
    input  logic          read,
    input  logic [AW-1:0] read_address,
    output logic [31:0]   DATA_in,
    output logic          stall,
    output logic          misalign,
    output logic          empty,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RAW_DRAIN, RD_WAIT} state_e;

    logic [AW-3:0] waddr_q [DEPTH];
    logic [3:0]    be_q    [DEPTH];
    logic [31:0]   wdata_q [DEPTH];
    logic [PW:0]   wr_q, rd_q, count;
    logic [31:0]   rdata_q;
    state_e        state_q, state_d;

    logic        mis, hit, load_go, drain, pop, push;
    logic [3:0]  enq_be;
    logic [31:0] enq_data;
    logic [PW-1:0] off;

    assign count = wr_q - rd_q;

    // Lane alignment, byte enables and misalignment of the incoming store
    always_comb begin
        enq_be   = 4'b1111;
        enq_data = DATA_out;
        mis      = 1'b0;
        if (size == 2'b00) begin
            enq_be   = 4'b0001 << write_address[1:0];
            enq_data = {4{DATA_out[7:0]}};
        end else if (size == 2'b01) begin
            enq_be   = write_address[1] ? 4'b1100 : 4'b0011;
            enq_data = {2{DATA_out[15:0]}};
            mis      = write_address[0];
        end else begin
            mis      = (write_address[1:0] != 2'b00);
        end
    end

    // Word-address match of the load against every live entry
    always_comb begin
        hit = 1'b0;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_q[PW-1:0];
            if (({1'b0, off} < count) &&
                (waddr_q[i] == read_address[AW-1:2]))
                hit = 1'b1;
        end
    end

    // Bus arbitration, next state, stall and core-facing outputs
    always_comb begin
        load_go  = (state_q == IDLE) && read && !write && !hit;
        drain    = (count != '0) && !load_go;
        pop      = drain && mem_gnt;
        push     = write && !mis &&
                   ((count < (PW+1)'(DEPTH)) || pop);
        state_d  = state_q;
        stall    = write && !mis && !push;
        DATA_in  = rdata_q;
        misalign = write && mis;
        empty    = (count == '0) && (state_q == IDLE);
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_be   = 4'b0000;
        mem_wdata = '0;
        if (load_go) begin
            mem_req  = 1'b1;
            mem_addr = {read_address[AW-1:2], 2'b00};
            mem_be   = 4'b1111;
        end else if (drain) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {waddr_q[rd_q[PW-1:0]], 2'b00};
            mem_be    = be_q[rd_q[PW-1:0]];
            mem_wdata = wdata_q[rd_q[PW-1:0]];
        end
        unique case (state_q)
            IDLE: begin
                if (read) begin
                    stall = 1'b1;
                    if (!write) begin
                        if (hit)
                            state_d = RAW_DRAIN;
                        else if (mem_gnt)
                            state_d = RD_WAIT;
                    end
                end
            end
            RAW_DRAIN: begin
                stall = 1'b1;
                if (!hit)
                    state_d = IDLE;
            end
            RD_WAIT: begin
                if (mem_rvalid) begin
                    DATA_in = mem_rdata;
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            state_d   = IDLE;
            pop       = 1'b0;
            push      = 1'b0;
            stall     = 1'b0;
            DATA_in   = '0;
            misalign  = 1'b0;
            empty     = 1'b1;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_be    = 4'b0000;
            mem_wdata = '0;
        end
    end

    // Pointers, FSM state and held load data
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            if (push)
                wr_q <= wr_q + 1'b1;
            if (pop)
                rd_q <= rd_q + 1'b1;
            state_q <= state_d;
            if (state_q == RD_WAIT && mem_rvalid)
                rdata_q <= mem_rdata;
        end
    end

    // Entry storage, written at the tail on acceptance
    always_ff @(posedge clk) begin
        if (push) begin
            waddr_q[wr_q[PW-1:0]] <= write_address[AW-1:2];
            be_q[wr_q[PW-1:0]]    <= enq_be;
            wdata_q[wr_q[PW-1:0]] <= enq_data;
        end
    end

endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
- Sits directly downstream of the core's data-memory port (read/write address, DATA_out, size, write, read, DATA_in) and drives a single-port data-memory bus.
- Posted stores go into a DEPTH-entry FIFO and drain to memory in the background. Loads go to memory with priority over the drain.
- A load that hits a buffered store's word address (read-after-write) drains the buffer before it is issued.
- Lane alignment, byte-enable generation and misalignment detection happen here.

Parameters:
DEPTH, 4, number of store-buffer entries (power of two, ≥2)
AW, 32, address width

Ports:
clk  in  1  rising-edge clock, only clock
reset  in  1  synchronous, active-high reset
write  in  1  core store request (held while stall=1)
write_address  in  AW  store byte address
DATA_out  in  32  store data, right-aligned
size  in  2  00 byte, 01 half, 10/11 word
read  in  1  core load request (held while stall=1)
read_address  in  AW  load byte address
DATA_in  out  32  load word returned to core (unshifted)
stall  out  1  core must hold its request this cycle
misalign  out  1  one-cycle pulse: misaligned store dropped
empty  out  1  buffer empty and no memory op outstanding
mem_req  out  1  memory request
mem_we  out  1  1 store, 0 load
mem_addr  out  AW  word-aligned address ({addr[AW-1:2],2'b00})
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  load data valid (exactly 1 cycle after read grant)
mem_rdata  in  32  load data

Behaviour:
- Reset values: FIFO empty, FSM IDLE, DATA_in=0, stall=0, misalign=0, empty=1, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
- Reset asserted mid-operation discards all entries and any outstanding read; a late mem_rvalid is ignored.
- Enqueue, computed on acceptance:
  - byte: be=1<<addr[1:0], data={4{DATA_out[7:0]}}
  - half: be=addr[1]?1100:0011, data={2{DATA_out[15:0]}}
  - word: be=1111, data=DATA_out
- Misaligned stores (half with addr[0]=1, or word with addr[1:0]≠0) are not enqueued. misalign pulses for 1 cycle and stall=0.
- A store is accepted when write=1 and (count<DEPTH or a pop occurs the same cycle); otherwise stall=1.
- Store write and read asserted together: the store is handled first; the read is treated as not yet seen and is stalled one cycle.
- Drain: when the FIFO is non-empty and no load owns the bus, the head entry is driven on mem_* with mem_req=1, mem_we=1. It pops on mem_gnt, and the next entry may be driven the next cycle.
- FSM states and transitions:
  - IDLE, read=1, no hit (no entry with equal word address): drive a load request combinationally (mem_we=0, be=1111), taking priority over the drain.
    - mem_gnt=1 → RD_WAIT.
    - else stay, stall=1.
  - IDLE, read=1, any hit → RAW_DRAIN, stall=1.
  - RAW_DRAIN: drain continues; stall=1. When no entry hits → IDLE, and the load issues next cycle.
  - RD_WAIT: stall=1 until mem_rvalid=1. In that cycle DATA_in=mem_rdata (combinational bypass) and stall=0; the value is registered and held in DATA_in afterwards → IDLE.
- Load latency with no hit and gnt=1: request cycle N, data cycle N+1; stall is high in N only.
- Count wraps via pointers of log2(DEPTH)+1 bits.
- FIFO full with simultaneous pop and push: both occur and count is unchanged.
- empty=(count==0)&&(state==IDLE).
- Stores are never reordered with respect to each other, and memory sees them in program order.

Test Plan:
- Reset then idle, mem_gnt=1 → all outputs at reset values, empty=1, mem_req=0 for 10 cycles.
- Store byte 0xAB to 0x103, gnt=1 → next cycle mem_req=1, mem_we=1, mem_addr=0x100, mem_be=1000, mem_wdata=0xABABABAB; empty=1 after the grant.
- mem_gnt=0, then 5 word stores 0x10,0x14,0x18,0x1C,0x20 → first 4 accepted; stall=1 on the 5th. Raise gnt → stores drain in order, the 5th is accepted on the first pop cycle, then empty=1.
- Load from 0x40 with buffer empty, gnt=1, rdata=0xDEADBEEF next cycle → stall high 1 cycle, DATA_in=0xDEADBEEF and held afterwards.
- Buffered store to 0x80 (gnt held low), then load 0x82 → stall stays 1 (RAW_DRAIN). On gnt the store drains, then the load issues to 0x80 and returns the memory value.
- Half store to 0x101 → misalign pulse, no mem_req, count unchanged. Then assert reset while a load is in RD_WAIT → state IDLE, stall=0, and the next-cycle mem_rvalid is ignored (DATA_in stays 0).
